// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: bus word, RV32I width codes, FSM states.
package types;

    typedef logic [31:0] bus_type;

    // RV32I funct3 width/sign codes understood by the unit.
    typedef enum logic [2:0] {
        OP_B  = 3'b000,
        OP_H  = 3'b001,
        OP_W  = 3'b010,
        OP_BU = 3'b100,
        OP_HU = 3'b101
    } lsu_op_type;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_type;

    // Byte address to word index into the data memory.
    function automatic bus_type word_index(input bus_type addr);
        return addr >> 2;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational data alignment: load extraction/extension and
// read-modify-write merge for sub-word stores.
module lsu_align
    import types::*;
(
    input  lsu_op_type op,
    input  logic [1:0] byte_off,
    input  bus_type    word,
    input  bus_type    wdata,
    output bus_type    load_data,
    output bus_type    store_word
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Pick the addressed byte and halfword; halfword only looks at byte_off[1].
    always_comb begin
        sel_byte = word[7:0];
        case (byte_off)
            2'd0: sel_byte = word[7:0];
            2'd1: sel_byte = word[15:8];
            2'd2: sel_byte = word[23:16];
            2'd3: sel_byte = word[31:24];
            default: sel_byte = word[7:0];
        endcase
        sel_half = byte_off[1] ? word[31:16] : word[15:0];
    end

    // Extend the selected lane according to the width/sign code.
    always_comb begin
        load_data = word;
        case (op)
            OP_B:  load_data = {{24{sel_byte[7]}}, sel_byte};
            OP_BU: load_data = {24'd0, sel_byte};
            OP_H:  load_data = {{16{sel_half[15]}}, sel_half};
            OP_HU: load_data = {16'd0, sel_half};
            default: load_data = word;
        endcase
    end

    // Merge store data into the current memory word; full words pass through.
    always_comb begin
        store_word = wdata;
        case (op)
            OP_B: begin
                store_word = word;
                case (byte_off)
                    2'd0: store_word[7:0]   = wdata[7:0];
                    2'd1: store_word[15:8]  = wdata[7:0];
                    2'd2: store_word[23:16] = wdata[7:0];
                    2'd3: store_word[31:24] = wdata[7:0];
                    default: store_word[7:0] = wdata[7:0];
                endcase
            end
            OP_H: begin
                store_word = word;
                if (byte_off[1]) store_word[31:16] = wdata[15:0];
                else             store_word[15:0]  = wdata[15:0];
            end
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, IDLE -> (READ) -> (WRITE) -> RESP.
// Optional LSU_MISALIGN_TRAP_EN: fault misaligned halfword/word accesses
// instead of silently ignoring the low address bits.
module load_store_unit
    import types::*;
#(
    parameter int MEM_WORDS = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [2:0] req_funct3,
    input  bus_type    req_addr,
    input  bus_type    req_wdata,
    output logic       resp_valid,
    input  logic       resp_ready,
    output bus_type    resp_rdata,
    output logic       resp_err,
    output bus_type    mem_address,
    output bus_type    mem_input_data,
    output logic       mem_enable_read,
    output logic       mem_enable_write,
    input  bus_type    mem_read_data
);

    localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

    lsu_state_type state_q;
    logic          write_q;
    lsu_op_type    op_q;
    bus_type       addr_q;
    bus_type       wdata_q;

    logic          req_ready_q;
    logic          resp_valid_q;
    bus_type       resp_rdata_q;
    logic          resp_err_q;
    bus_type       mem_address_q;
    bus_type       mem_input_data_q;
    logic          mem_rd_q;
    logic          mem_wr_q;

    lsu_op_type    req_op;
    logic          req_fault;
    logic          req_misalign;
    bus_type       load_data;
    bus_type       store_word;

    // Classify the incoming request: illegal code, store of BU/HU, out of range, misaligned.
    always_comb begin
        req_op       = lsu_op_type'(req_funct3);
        req_fault    = 1'b0;
        req_misalign = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: req_fault = 1'b0;
            3'b100, 3'b101:         req_fault = req_write;
            default:                req_fault = 1'b1;
        endcase
        if (req_addr[31:2] >= WORD_LIMIT) req_fault = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        case (req_funct3)
            3'b001, 3'b101: req_misalign = req_addr[0];
            3'b010:         req_misalign = |req_addr[1:0];
            default:        req_misalign = 1'b0;
        endcase
`else
        req_misalign = 1'b0;
`endif
        req_fault = req_fault | req_misalign;
    end

    lsu_align u_align (
        .op         (op_q),
        .byte_off   (addr_q[1:0]),
        .word       (mem_read_data),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // Control FSM; every output is registered and set on the transition into its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            write_q          <= 1'b0;
            op_q             <= OP_B;
            addr_q           <= '0;
            wdata_q          <= '0;
            req_ready_q      <= 1'b1;
            resp_valid_q     <= 1'b0;
            resp_rdata_q     <= '0;
            resp_err_q       <= 1'b0;
            mem_address_q    <= '0;
            mem_input_data_q <= '0;
            mem_rd_q         <= 1'b0;
            mem_wr_q         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        write_q     <= req_write;
                        op_q        <= req_op;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        if (req_fault) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else if (!req_write || req_funct3 != 3'b010) begin
                            // loads and sub-word stores need the current word first
                            state_q       <= READ;
                            mem_rd_q      <= 1'b1;
                            mem_address_q <= word_index(req_addr);
                        end else begin
                            state_q          <= WRITE;
                            mem_wr_q         <= 1'b1;
                            mem_address_q    <= word_index(req_addr);
                            mem_input_data_q <= req_wdata;
                        end
                    end
                end
                READ: begin
                    mem_rd_q <= 1'b0;
                    if (write_q) begin
                        state_q          <= WRITE;
                        mem_wr_q         <= 1'b1;
                        mem_address_q    <= word_index(addr_q);
                        mem_input_data_q <= store_word;
                    end else begin
                        state_q       <= RESP;
                        mem_address_q <= '0;
                        resp_valid_q  <= 1'b1;
                        resp_err_q    <= 1'b0;
                        resp_rdata_q  <= load_data;
                    end
                end
                WRITE: begin
                    state_q          <= RESP;
                    mem_wr_q         <= 1'b0;
                    mem_address_q    <= '0;
                    mem_input_data_q <= '0;
                    resp_valid_q     <= 1'b1;
                    resp_err_q       <= 1'b0;
                    resp_rdata_q     <= '0;
                end
                RESP: begin
                    // no new request is taken on the handshake edge
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        req_ready_q  <= 1'b1;
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready        = req_ready_q;
    assign resp_valid       = resp_valid_q;
    assign resp_rdata       = resp_rdata_q;
    assign resp_err         = resp_err_q;
    assign mem_address      = mem_address_q;
    assign mem_input_data   = mem_input_data_q;
    assign mem_enable_read  = mem_rd_q;
    assign mem_enable_write = mem_wr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural data memory and a
// response scoreboard (expected data/err/latency pushed on issue, popped on response).
module tb_load_store_unit;
    import types::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [2:0] req_funct3;
    bus_type    req_addr;
    bus_type    req_wdata;
    logic       resp_valid;
    logic       resp_ready;
    bus_type    resp_rdata;
    logic       resp_err;
    bus_type    mem_address;
    bus_type    mem_input_data;
    logic       mem_enable_read;
    logic       mem_enable_write;
    bus_type    mem_read_data;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_rdata       (resp_rdata),
        .resp_err         (resp_err),
        .mem_address      (mem_address),
        .mem_input_data   (mem_input_data),
        .mem_enable_read  (mem_enable_read),
        .mem_enable_write (mem_enable_write),
        .mem_read_data    (mem_read_data)
    );

    bus_type mem [32];
    int      wr_cnt = 0;
    int      rd_cnt = 0;

    assign mem_read_data = mem[mem_address[4:0]];

    always @(posedge clk) begin
        if (mem_enable_write) begin
            mem[mem_address[4:0]] <= mem_input_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (mem_enable_read) rd_cnt <= rd_cnt + 1;
    end

    typedef struct {
        bus_type rdata;
        logic    err;
        int      lat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request, measure edges from accept to resp_valid, check against scoreboard.
    task automatic run_req(input string tag, input logic wr, input logic [2:0] f3,
                           input bus_type a, input bus_type wd,
                           input bus_type erd, input logic eerr, input int elat);
        exp_t e;
        int   lat;
        int   wc0, rc0;
        @(negedge clk);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
        sb.push_back('{erd, eerr, elat});
        wc0 = wr_cnt; rc0 = rd_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        chk({tag, "_lat"},   32'(lat),        32'(e.lat));
        chk({tag, "_rdata"}, resp_rdata,      e.rdata);
        chk({tag, "_err"},   32'(resp_err),   32'(e.err));
        @(posedge clk); #1;
        chk({tag, "_done"},  32'(resp_valid), 32'd0);
        if (eerr) chk({tag, "_nomem"}, 32'((wr_cnt - wc0) + (rd_cnt - rc0)), 32'd0);
        if (wr)   chk({tag, "_wrcnt"}, 32'(wr_cnt - wc0), eerr ? 32'd0 : 32'd1);
    endtask

    initial begin
        exp_t    e;
        int      lat;
        int      wc0;
        bus_type m3;
        bus_type exp_lw6;
        logic    exp_lw6_err;
        int      exp_lw6_lat;
        bus_type exp_lh7;
        logic    exp_lh7_err;
        int      exp_lh7_lat;

        for (int i = 0; i < 32; i++) mem[i] <= 32'h0101_0101 * i;
        mem[1] <= 32'h1122_3344;
        mem[3] <= 32'h8899_AABB;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b1;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err",   32'(resp_err), 32'd0);
        chk("rst_mem_en",     32'({mem_enable_read, mem_enable_write}), 32'd0);
        chk("rst_req_ready",  32'(req_ready), 32'd1);
        rst_n = 1'b1;

        // loads from mem[3] = 0x8899AABB
        run_req("lb_0d",  1'b0, 3'b000, 32'h0D, 32'h0, 32'hFFFF_FFAA, 1'b0, 2);
        run_req("lbu_0d", 1'b0, 3'b100, 32'h0D, 32'h0, 32'h0000_00AA, 1'b0, 2);
        run_req("lb_0c",  1'b0, 3'b000, 32'h0C, 32'h0, 32'hFFFF_FFBB, 1'b0, 2);
        run_req("lbu_0f", 1'b0, 3'b100, 32'h0F, 32'h0, 32'h0000_0088, 1'b0, 2);
        run_req("lh_0e",  1'b0, 3'b001, 32'h0E, 32'h0, 32'hFFFF_8899, 1'b0, 2);
        run_req("lhu_0e", 1'b0, 3'b101, 32'h0E, 32'h0, 32'h0000_8899, 1'b0, 2);
        run_req("lw_0c",  1'b0, 3'b010, 32'h0C, 32'h0, 32'h8899_AABB, 1'b0, 2);
        run_req("lh_04",  1'b0, 3'b001, 32'h04, 32'h0, 32'h0000_3344, 1'b0, 2);

        // stores
        run_req("sh_0e", 1'b1, 3'b001, 32'h0E, 32'h0000_1234, 32'h0, 1'b0, 3);
        chk("sh_0e_mem", mem[3], 32'h1234_AABB);
        run_req("sb_0c", 1'b1, 3'b000, 32'h0C, 32'hFFFF_FF55, 32'h0, 1'b0, 3);
        chk("sb_0c_mem", mem[3], 32'h1234_AA55);
        run_req("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 2);
        chk("sw_10_mem", mem[4], 32'hDEAD_BEEF);
        run_req("lw_10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 2);

        // faults: out of range, illegal codes, unsigned store codes
        run_req("lw_80",  1'b0, 3'b010, 32'h80,       32'h0, 32'h0, 1'b1, 1);
        run_req("lb_big", 1'b0, 3'b000, 32'hFFFF_FFF0, 32'h0, 32'h0, 1'b1, 1);
        run_req("ld_011", 1'b0, 3'b011, 32'h04,       32'h0, 32'h0, 1'b1, 1);
        run_req("ld_111", 1'b0, 3'b111, 32'h04,       32'h0, 32'h0, 1'b1, 1);
        run_req("st_100", 1'b1, 3'b100, 32'h04,       32'h55, 32'h0, 1'b1, 1);
        run_req("st_101", 1'b1, 3'b101, 32'h04,       32'h55, 32'h0, 1'b1, 1);
        chk("st_fault_mem", mem[1], 32'h1122_3344);

        // alignment behaviour depends on configuration
`ifdef LSU_MISALIGN_TRAP_EN
        exp_lw6 = 32'h0; exp_lw6_err = 1'b1; exp_lw6_lat = 1;
        exp_lh7 = 32'h0; exp_lh7_err = 1'b1; exp_lh7_lat = 1;
`else
        exp_lw6 = 32'h1122_3344; exp_lw6_err = 1'b0; exp_lw6_lat = 2;
        exp_lh7 = 32'h0000_1122; exp_lh7_err = 1'b0; exp_lh7_lat = 2;
`endif
        run_req("lw_06", 1'b0, 3'b010, 32'h06, 32'h0, exp_lw6, exp_lw6_err, exp_lw6_lat);
        run_req("lh_07", 1'b0, 3'b001, 32'h07, 32'h0, exp_lh7, exp_lh7_err, exp_lh7_lat);

        // back-pressure: response held 5 cycles, next request waits until after handshake
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h04; req_wdata = '0;
        sb.push_back('{32'h1122_3344, 1'b0, 2});
        @(posedge clk); #1;
        req_addr = 32'h0C;
        sb.push_back('{32'h1234_AA55, 1'b0, 2});
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        chk("bp_lat", 32'(lat), 32'(e.lat));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 32'(resp_valid), 32'd1);
            chk("bp_hold_rdata", resp_rdata, e.rdata);
            chk("bp_hold_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_hs_valid", 32'(resp_valid), 32'd0);
        chk("bp_hs_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        chk("bp_accept", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        e = sb.pop_front();
        chk("bp2_lat",   32'(lat), 32'(e.lat));
        chk("bp2_rdata", resp_rdata, e.rdata);
        @(posedge clk); #1;

        // reset during the READ phase of a byte store
        m3 = mem[3];
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000; req_addr = 32'h0C; req_wdata = 32'h77;
        wc0 = wr_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rr_in_read", 32'(mem_enable_read), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rr_wr_en",   32'(mem_enable_write), 32'd0);
        chk("rr_rd_en",   32'(mem_enable_read), 32'd0);
        chk("rr_addr",    mem_address, 32'd0);
        chk("rr_wdata",   mem_input_data, 32'd0);
        chk("rr_valid",   32'(resp_valid), 32'd0);
        chk("rr_rdata",   resp_rdata, 32'd0);
        chk("rr_err",     32'(resp_err), 32'd0);
        chk("rr_ready",   32'(req_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("rr_no_write", 32'(wr_cnt - wc0), 32'd0);
        chk("rr_mem3",     mem[3], m3);
        @(negedge clk);
        rst_n = 1'b1;
        run_req("post_rst_lw", 1'b0, 3'b010, 32'h0C, 32'h0, m3, 1'b0, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
